dequant_invscan_4x4: RTL and testbench

//  Upstream feeder for IDCT_whole. Accepts quantized 4x4 coefficient levels one per cycle
//  in zigzag order, dequantizes each (level*q_scale<<<Q_SHIFT, saturated to 25 bits), and

---
 rtl/dequant_invscan_4x4.sv | 156 +++++++++++++++
 tb/tb_dequant_invscan_4x4.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dequant_invscan_4x4.sv
// Dequantizes zigzag-ordered 4x4 coefficient levels into a raster buffer and
// emits the finished block as four registered rows for the downstream IDCT.
module dequant_invscan_4x4 #(
  parameter int LVL_W   = 16,
  parameter int SCL_W   = 8,
  parameter int Q_SHIFT = 2,
  parameter int OUT_W   = 25
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [LVL_W-1:0] coef_in,
  input  logic        [SCL_W-1:0] q_scale,
  input  logic                    coef_valid,
  input  logic                    coef_last,
  output logic                    coef_ready,
  output logic                    out_valid,
  output logic                    out_sob,
  output logic signed [OUT_W-1:0] d_out_1,
  output logic signed [OUT_W-1:0] d_out_2,
  output logic signed [OUT_W-1:0] d_out_3,
  output logic signed [OUT_W-1:0] d_out_4
);

  // state  | meaning
  // S_FILL | accepting levels into the raster buffer
  // S_EMIT | presenting rows 0..3, no input accepted
  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  localparam int P_W = LVL_W + SCL_W + 1;
  localparam int R_W = P_W + Q_SHIFT;
  localparam logic signed [R_W-1:0] SAT_MAX = {{(R_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [R_W-1:0] SAT_MIN = ~SAT_MAX;

  logic [0:0]              state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic [1:0]              row_q, row_d;
  logic signed [OUT_W-1:0] buf_q [16];
  logic signed [OUT_W-1:0] buf_d [16];
  logic signed [OUT_W-1:0] dout_q [4];
  logic signed [OUT_W-1:0] dout_d [4];
  logic                    valid_q, valid_d;
  logic                    sob_q, sob_d;

  logic                    accept, term;
  logic [1:0]              row_sel;
  logic signed [P_W-1:0]   a_ext, b_ext, prod;
  logic signed [R_W-1:0]   shifted;
  logic signed [OUT_W-1:0] deq;

  function automatic logic [3:0] zz_pos(input logic [3:0] k);
    case (k)
      4'd0:  zz_pos = 4'd0;
      4'd1:  zz_pos = 4'd1;
      4'd2:  zz_pos = 4'd4;
      4'd3:  zz_pos = 4'd8;
      4'd4:  zz_pos = 4'd5;
      4'd5:  zz_pos = 4'd2;
      4'd6:  zz_pos = 4'd3;
      4'd7:  zz_pos = 4'd6;
      4'd8:  zz_pos = 4'd9;
      4'd9:  zz_pos = 4'd12;
      4'd10: zz_pos = 4'd13;
      4'd11: zz_pos = 4'd10;
      4'd12: zz_pos = 4'd7;
      4'd13: zz_pos = 4'd11;
      4'd14: zz_pos = 4'd14;
      default: zz_pos = 4'd15;
    endcase
  endfunction

  assign coef_ready = (state_q == S_FILL);
  assign accept     = coef_valid && coef_ready;
  assign term       = accept && (coef_last || (idx_q == 4'd15));

  // Shift in the widened domain so saturation sees the true magnitude.
  always_comb begin
    a_ext   = P_W'(coef_in);
    b_ext   = P_W'($signed({1'b0, q_scale}));
    prod    = a_ext * b_ext;
    shifted = R_W'(prod) <<< Q_SHIFT;
    if (shifted > SAT_MAX)      deq = SAT_MAX[OUT_W-1:0];
    else if (shifted < SAT_MIN) deq = SAT_MIN[OUT_W-1:0];
    else                        deq = shifted[OUT_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    row_d   = row_q;
    buf_d   = buf_q;
    valid_d = 1'b0;
    sob_d   = 1'b0;
    row_sel = 2'd0;
    for (int c = 0; c < 4; c++) dout_d[c] = '0;
    case (state_q)
      S_FILL: begin
        if (accept) begin
          buf_d[zz_pos(idx_q)] = deq;
          if (term) begin
            state_d = S_EMIT;
            idx_d   = 4'd0;
            row_d   = 2'd0;
            valid_d = 1'b1;
            sob_d   = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: begin
        if (row_q == 2'd3) begin
          state_d = S_FILL;
          row_d   = 2'd0;
          for (int i = 0; i < 16; i++) buf_d[i] = '0;
        end else begin
          row_d   = row_q + 2'd1;
          row_sel = row_q + 2'd1;
          valid_d = 1'b1;
        end
      end
    endcase
    // Row 0 is taken from buf_d so the terminating coefficient is included.
    if (valid_d) begin
      for (int c = 0; c < 4; c++) dout_d[c] = buf_d[{row_sel, 2'(c)}];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FILL;
      idx_q   <= 4'd0;
      row_q   <= 2'd0;
      valid_q <= 1'b0;
      sob_q   <= 1'b0;
      for (int i = 0; i < 16; i++) buf_q[i] <= '0;
      for (int c = 0; c < 4; c++) dout_q[c] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      sob_q   <= sob_d;
      buf_q   <= buf_d;
      dout_q  <= dout_d;
    end
  end

  assign out_valid = valid_q;
  assign out_sob   = sob_q;
  assign d_out_1   = dout_q[0];
  assign d_out_2   = dout_q[1];
  assign d_out_3   = dout_q[2];
  assign d_out_4   = dout_q[3];

endmodule

// File: tb/tb_dequant_invscan_4x4.sv
// Directed bench for dequant_invscan_4x4 (default parameters, Q_SHIFT=2):
// rows are captured by a monitor and compared with hand-computed values.
module tb_dequant_invscan_4x4;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] coef_in;
  logic        [7:0]  q_scale;
  logic               coef_valid, coef_last;
  logic               coef_ready, out_valid, out_sob;
  logic signed [24:0] d_out_1, d_out_2, d_out_3, d_out_4;

  typedef struct packed {
    logic               sob;
    logic [31:0]        cyc;
    logic signed [24:0] d0;
    logic signed [24:0] d1;
    logic signed [24:0] d2;
    logic signed [24:0] d3;
  } row_t;

  row_t        rows[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] cyc      = 0;
  int          low_cnt  = 0;
  bit          mon_en   = 0;
  int          zz[16]   = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

  dequant_invscan_4x4 dut (
    .clk(clk), .reset(reset), .coef_in(coef_in), .q_scale(q_scale),
    .coef_valid(coef_valid), .coef_last(coef_last), .coef_ready(coef_ready),
    .out_valid(out_valid), .out_sob(out_sob),
    .d_out_1(d_out_1), .d_out_2(d_out_2), .d_out_3(d_out_3), .d_out_4(d_out_4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Outputs settle after posedge; the negedge sees them stable.
  always @(negedge clk) begin
    if (mon_en) begin
      check("ready_vs_valid", coef_ready, !out_valid);
      if (!coef_ready) low_cnt++;
      if (out_valid) begin
        rows.push_back('{sob: out_sob, cyc: cyc, d0: d_out_1, d1: d_out_2, d2: d_out_3, d3: d_out_4});
      end else begin
        check("idle_zero", {out_sob, d_out_1, d_out_2, d_out_3, d_out_4}, 0);
      end
    end
  end

  task automatic send(input logic signed [15:0] c, input logic [7:0] s, input logic l);
    int g = 0;
    coef_in = c; q_scale = s; coef_last = l; coef_valid = 1'b1;
    while (!coef_ready && g < 50) begin @(negedge clk); g++; end
    if (!coef_ready) check("ready_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic idle();
    coef_valid = 1'b0; coef_last = 1'b0; coef_in = '0; q_scale = '0;
  endtask

  task automatic get_row(output row_t r);
    int g = 0;
    while (rows.size() == 0 && g < 200) begin @(negedge clk); g++; end
    if (rows.size() == 0) begin
      check("row_timeout", 0, 1);
      r = '0;
    end else begin
      r = rows.pop_front();
    end
  endtask

  task automatic chk_row(input string tag, input longint e0, input longint e1,
                         input longint e2, input longint e3, input bit sob,
                         output logic [31:0] rc);
    row_t r;
    get_row(r);
    check({tag, "_sob"}, r.sob, sob);
    check({tag, "_c0"}, r.d0, e0);
    check({tag, "_c1"}, r.d1, e1);
    check({tag, "_c2"}, r.d2, e2);
    check({tag, "_c3"}, r.d3, e3);
    rc = r.cyc;
  endtask

  function automatic longint model(input longint c, input longint s);
    longint v = c * s * 4;
    if (v > 16777215) v = 16777215;
    if (v < -16777216) v = -16777216;
    return v;
  endfunction

  initial begin
    logic [31:0] c0, c1;
    logic [31:0] sob_cyc[3];
    longint      exp_blk[3][16];
    int          lc;

    reset = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    check("rst_ready", coef_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_dout", {out_sob, d_out_1, d_out_2, d_out_3, d_out_4}, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // DC only
    lc = low_cnt;
    send(-180, 1, 1);
    idle();
    check("t1_latency", out_valid, 1);
    chk_row("t1_r0", -720, 0, 0, 0, 1, c0);
    for (int i = 1; i < 4; i++) begin
      chk_row("t1_rn", 0, 0, 0, 0, 0, c1);
      check("t1_contig", c1 - c0, i);
    end
    repeat (3) @(negedge clk);
    check("t1_ready_low", low_cnt - lc, 4);

    // zigzag map, k+1 scaled by 4
    for (int k = 0; k < 16; k++) send(16'(k + 1), 1, 0);
    idle();
    chk_row("t2_r0", 4, 8, 24, 28, 1, c0);
    chk_row("t2_r1", 12, 20, 32, 52, 0, c0);
    chk_row("t2_r2", 16, 36, 48, 56, 0, c0);
    chk_row("t2_r3", 40, 44, 60, 64, 0, c0);

    // full block of 5s (last on 16th), then an early-last block
    for (int k = 0; k < 16; k++) send(5, 1, k == 15);
    send(0, 1, 0);
    send(360, 1, 1);
    idle();
    chk_row("t3a_r0", 20, 20, 20, 20, 1, c0);
    for (int i = 1; i < 4; i++) chk_row("t3a_rn", 20, 20, 20, 20, 0, c0);
    chk_row("t3b_r0", 0, 1440, 0, 0, 1, c0);
    for (int i = 1; i < 4; i++) chk_row("t3b_rn", 0, 0, 0, 0, 0, c0);

    // saturation both ways, a large non-saturating value, and a zero scale
    send(32767, 255, 0);
    send(-32768, 255, 0);
    send(32767, 127, 0);
    send(-5, 3, 0);
    send(1000, 0, 1);
    idle();
    chk_row("t4_r0", 16777215, -16777216, 0, 0, 1, c0);
    chk_row("t4_r1", 16645636, 0, 0, 0, 0, c0);
    chk_row("t4_r2", -60, 0, 0, 0, 0, c0);
    chk_row("t4_r3", 0, 0, 0, 0, 0, c0);

    // continuous coef_valid over three blocks
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) exp_blk[b][i] = 0;
      for (int k = 0; k < 16; k++) exp_blk[b][zz[k]] = model(b * 100 + k + 1, b + 1);
    end
    for (int b = 0; b < 3; b++)
      for (int k = 0; k < 16; k++) send(16'(b * 100 + k + 1), 8'(b + 1), 0);
    idle();
    for (int b = 0; b < 3; b++) begin
      for (int r = 0; r < 4; r++) begin
        chk_row("t5_row", exp_blk[b][r*4], exp_blk[b][r*4+1], exp_blk[b][r*4+2],
                exp_blk[b][r*4+3], r == 0, c0);
        if (r == 0) sob_cyc[b] = c0;
      end
    end
    check("t5_period01", sob_cyc[1] - sob_cyc[0], 20);
    check("t5_period12", sob_cyc[2] - sob_cyc[1], 20);

    // reset after 7 accepts discards the partial block
    for (int k = 0; k < 7; k++) send(9, 1, 0);
    idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("t6_no_rows", rows.size(), 0);
    check("t6_ready", coef_ready, 1);
    for (int k = 0; k < 16; k++) send(16'(k + 1), 2, 0);
    idle();
    chk_row("t6_r0", 8, 16, 48, 56, 1, c0);
    chk_row("t6_r1", 24, 40, 64, 104, 0, c0);
    chk_row("t6_r2", 32, 72, 96, 112, 0, c0);
    chk_row("t6_r3", 80, 88, 120, 128, 0, c0);
    repeat (4) @(negedge clk);
    check("end_rows_empty", rows.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
